// File: rtl/prores_pkg.sv
// Shared constants, state encoding and helpers for the bit-stream packer.
package prores_pkg;

    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned BUF_BITS      = 64;
    localparam int unsigned MAX_CODE_BITS = 32;
    localparam int unsigned FILL_W        = 6;   // fill count 0..63
    localparam int unsigned LEN_W         = 7;   // examined code-length bits
    localparam int unsigned CNT_W         = 3;   // byte count 1..4

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } packer_state_t;

    // One output-memory write payload.
    typedef struct packed {
        logic [WORD_BITS-1:0] data;
        logic [CNT_W-1:0]     byte_cnt;
    } wr_word_t;

    // Round a bit count up to the next byte boundary.
    function automatic logic [LEN_W-1:0] pad_to_byte(input logic [LEN_W-1:0] bits);
        return (bits + LEN_W'(7)) & ~LEN_W'(7);
    endfunction

endpackage

// File: rtl/bitstream_packer_if.sv
// Code-stream input and memory-write output bundle of the bit-stream packer.
//   master: drives start/start_addr/enable/val/size_of_bit/flush, observes writes
//   slave : the packer itself
interface bitstream_packer_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              enable;
    logic [63:0]       val;
    logic [63:0]       size_of_bit;
    logic              flush;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [2:0]        wr_byte_cnt;
    logic [ADDR_W-1:0] bytes_written;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, start_addr, enable, val, size_of_bit, flush,
        input  wr_en, wr_addr, wr_data, wr_byte_cnt, bytes_written, busy, done, error
    );

    modport slave (
        input  start, start_addr, enable, val, size_of_bit, flush,
        output wr_en, wr_addr, wr_data, wr_byte_cnt, bytes_written, busy, done, error
    );

endinterface

// File: rtl/bitstream_packer_bit_append.sv
// bit_append: merge a right-justified code of len bits into a left-justified
// bit buffer directly below the fill bits already present.
//   buf_in/fill_in  : current buffer and number of valid MSBs (fill_in < 32)
//   val/len         : code value (bits at/above len ignored), length 0..32
//   buf_out/fill_out: merged buffer and new fill
module bit_append
    import prores_pkg::*;
(
    input  logic [BUF_BITS-1:0] buf_in,
    input  logic [FILL_W-1:0]   fill_in,
    input  logic [BUF_BITS-1:0] val,
    input  logic [FILL_W-1:0]   len,
    output logic [BUF_BITS-1:0] buf_out,
    output logic [FILL_W-1:0]   fill_out
);

    logic [BUF_BITS-1:0] mask;
    logic [BUF_BITS-1:0] code;
    logic [LEN_W-1:0]    shift_amt;

    // Mask off value bits above len, then place the code so its MSB lands at 63-fill.
    always_comb begin
        mask      = (len == '0) ? '0
                                : ({BUF_BITS{1'b1}} >> (LEN_W'(BUF_BITS) - LEN_W'(len)));
        code      = val & mask;
        shift_amt = LEN_W'(BUF_BITS) - LEN_W'(fill_in) - LEN_W'(len);
        buf_out   = buf_in | (code << shift_amt);
        fill_out  = fill_in + len;
    end

endmodule

// File: rtl/bitstream_packer.sv
// bitstream_packer: packs variable-length codes MSB-first into big-endian
// 32-bit memory words, pads to a byte boundary on flush and drains.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : start/start_addr/enable/val/size_of_bit/flush in;
//                    wr_en/wr_addr/wr_data/wr_byte_cnt/bytes_written/busy/done/error out
module bitstream_packer
    import prores_pkg::WORD_BITS, prores_pkg::BUF_BITS, prores_pkg::FILL_W,
           prores_pkg::LEN_W, prores_pkg::CNT_W, prores_pkg::packer_state_t,
           prores_pkg::RUN, prores_pkg::DRAIN, prores_pkg::wr_word_t,
           prores_pkg::pad_to_byte;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned MAX_CODE_BITS = 32
) (
    input logic               clock,
    input logic               reset_n,
    bitstream_packer_if.slave bus
);

    packer_state_t       state_q, state_d;
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   bw_q, bw_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    wr_word_t            wr_q, wr_d;

    // start view: everything as if cleared this cycle when start is high
    packer_state_t       cur_state;
    logic [BUF_BITS-1:0] cur_buf;
    logic [FILL_W-1:0]   cur_fill;
    logic [ADDR_W-1:0]   cur_base;
    logic [ADDR_W-1:0]   cur_bw;
    logic                cur_error;
    logic                cur_busy;

    logic [LEN_W-1:0]    code_len;
    logic                code_ok;
    logic [BUF_BITS-1:0] app_buf, sel_buf;
    logic [FILL_W-1:0]   app_fill, sel_fill;
    logic [LEN_W-1:0]    pad_fill;
    logic                unused_size_hi;

    assign code_len       = bus.size_of_bit[LEN_W-1:0];
    assign unused_size_hi = ^bus.size_of_bit[63:LEN_W];

    // Start takes priority: it clears state and latches the new base address.
    always_comb begin
        cur_state = bus.start ? RUN               : state_q;
        cur_buf   = bus.start ? '0                : buf_q;
        cur_fill  = bus.start ? '0                : fill_q;
        cur_base  = bus.start ? bus.start_addr    : base_q;
        cur_bw    = bus.start ? '0                : bw_q;
        cur_error = bus.start ? 1'b0              : error_q;
        cur_busy  = bus.start ? 1'b0              : busy_q;
        code_ok   = bus.enable && (code_len != '0) && (code_len <= LEN_W'(MAX_CODE_BITS));
    end

    bit_append u_bit_append (
        .buf_in   (cur_buf),
        .fill_in  (cur_fill),
        .val      (bus.val),
        .len      (code_len[FILL_W-1:0]),
        .buf_out  (app_buf),
        .fill_out (app_fill)
    );

    // Next-state, emit and counter logic.
    always_comb begin
        state_d   = cur_state;
        buf_d     = cur_buf;
        fill_d    = cur_fill;
        base_d    = cur_base;
        bw_d      = cur_bw;
        error_d   = cur_error;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_d      = '0;
        sel_buf   = cur_buf;
        sel_fill  = cur_fill;
        pad_fill  = '0;

        if (cur_state == DRAIN) begin
            // Second word of a drain; fill holds the padded remainder (8..32 bits).
            if (bus.enable || bus.flush) error_d = 1'b1;
            wr_en_d       = 1'b1;
            wr_addr_d     = cur_base + cur_bw;
            wr_d.data     = cur_buf[BUF_BITS-1 -: WORD_BITS];
            wr_d.byte_cnt = CNT_W'(cur_fill >> 3);
            bw_d          = cur_bw + ADDR_W'(wr_d.byte_cnt);
            done_d        = 1'b1;
            busy_d        = 1'b1;
            buf_d         = '0;
            fill_d        = '0;
            state_d       = RUN;
        end else if (cur_busy) begin
            // Drain just completed; inputs are still illegal this cycle.
            if (bus.enable || bus.flush) error_d = 1'b1;
        end else begin
            if (bus.enable && (code_len > LEN_W'(MAX_CODE_BITS))) error_d = 1'b1;
            if (code_ok) begin
                sel_buf  = app_buf;
                sel_fill = app_fill;
            end
            buf_d  = sel_buf;
            fill_d = sel_fill;

            if (bus.flush) begin
                pad_fill = pad_to_byte(LEN_W'(sel_fill));
                done_d   = (pad_fill <= LEN_W'(WORD_BITS));
                if (pad_fill != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_base + cur_bw;
                    wr_d.data = sel_buf[BUF_BITS-1 -: WORD_BITS];
                    if (pad_fill <= LEN_W'(WORD_BITS)) begin
                        wr_d.byte_cnt = CNT_W'(pad_fill >> 3);
                        buf_d         = '0;
                        fill_d        = '0;
                    end else begin
                        wr_d.byte_cnt = CNT_W'(4);
                        buf_d         = sel_buf << WORD_BITS;
                        fill_d        = FILL_W'(pad_fill - LEN_W'(WORD_BITS));
                        state_d       = DRAIN;
                    end
                    bw_d = cur_bw + ADDR_W'(wr_d.byte_cnt);
                end
            end else if (sel_fill >= FILL_W'(WORD_BITS)) begin
                wr_en_d       = 1'b1;
                wr_addr_d     = cur_base + cur_bw;
                wr_d.data     = sel_buf[BUF_BITS-1 -: WORD_BITS];
                wr_d.byte_cnt = CNT_W'(4);
                bw_d          = cur_bw + ADDR_W'(4);
                buf_d         = sel_buf << WORD_BITS;
                fill_d        = sel_fill - FILL_W'(WORD_BITS);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            buf_q     <= '0;
            fill_q    <= '0;
            base_q    <= '0;
            bw_q      <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_q      <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            base_q    <= base_d;
            bw_q      <= bw_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_q      <= wr_d;
        end
    end

    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_q.data;
    assign bus.wr_byte_cnt   = wr_q.byte_cnt;
    assign bus.bytes_written = bw_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;

endmodule

// File: tb/tb_bitstream_packer.sv
// Testbench for bitstream_packer: a bit-queue reference model predicts every
// output each cycle; directed sequences pin literal expectations.
module tb_bitstream_packer;

    localparam int unsigned ADDR_W = 32;

    logic clock = 1'b0;
    logic reset_n;

    bitstream_packer_if #(.ADDR_W(ADDR_W)) bus();

    bitstream_packer #(
        .ADDR_W        (ADDR_W),
        .MAX_CODE_BITS (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    bit          m_bits[$];        // pending bits, oldest first
    logic [31:0] m_base = '0;
    logic [31:0] m_bw   = '0;
    bit          m_err  = 1'b0;
    bit          m_drain_pending = 1'b0;
    bit          m_busy_window   = 1'b0;

    logic        exp_wr_en = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_data  = '0;
    logic [2:0]  exp_cnt   = '0;
    logic        exp_done  = 1'b0;
    logic        exp_busy  = 1'b0;

    task automatic m_emit(input int k);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < k * 8; i++) d[31 - i] = m_bits.pop_front();
        exp_wr_en = 1'b1;
        exp_addr  = m_base + m_bw;
        exp_data  = d;
        exp_cnt   = 3'(k);
        m_bw      = m_bw + 32'(k);
    endtask

    always @(posedge clock or negedge reset_n) begin
        int n;
        exp_wr_en = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_cnt   = '0;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
        if (!reset_n) begin
            m_bits.delete();
            m_base = '0;
            m_bw = '0;
            m_err = 1'b0;
            m_drain_pending = 1'b0;
            m_busy_window = 1'b0;
        end else begin
            if (bus.start) begin
                m_bits.delete();
                m_base = bus.start_addr;
                m_bw = '0;
                m_err = 1'b0;
                m_drain_pending = 1'b0;
                m_busy_window = 1'b0;
            end
            if (m_drain_pending) begin
                if (bus.enable || bus.flush) m_err = 1'b1;
                m_emit(m_bits.size() / 8);
                exp_done = 1'b1;
                exp_busy = 1'b1;
                m_drain_pending = 1'b0;
                m_busy_window = 1'b1;
            end else if (m_busy_window) begin
                if (bus.enable || bus.flush) m_err = 1'b1;
                m_busy_window = 1'b0;
            end else begin
                n = int'(bus.size_of_bit[6:0]);
                if (bus.enable && n > 32) m_err = 1'b1;
                else if (bus.enable) begin
                    for (int i = n - 1; i >= 0; i--) m_bits.push_back(bus.val[i]);
                end
                if (bus.flush) begin
                    while (m_bits.size() % 8 != 0) m_bits.push_back(1'b0);
                    if (m_bits.size() == 0) exp_done = 1'b1;
                    else if (m_bits.size() <= 32) begin
                        m_emit(m_bits.size() / 8);
                        exp_done = 1'b1;
                    end else begin
                        m_emit(4);
                        m_drain_pending = 1'b1;
                    end
                end else if (m_bits.size() >= 32) begin
                    m_emit(4);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("cyc_wr_en", 64'(bus.wr_en), 64'(exp_wr_en));
        if (exp_wr_en) begin
            chk("cyc_wr_addr", 64'(bus.wr_addr), 64'(exp_addr));
            chk("cyc_wr_data", 64'(bus.wr_data), 64'(exp_data));
            chk("cyc_wr_cnt",  64'(bus.wr_byte_cnt), 64'(exp_cnt));
        end
        chk("cyc_done",  64'(bus.done), 64'(exp_done));
        chk("cyc_busy",  64'(bus.busy), 64'(exp_busy));
        chk("cyc_error", 64'(bus.error), 64'(m_err));
        chk("cyc_bytes_written", 64'(bus.bytes_written), 64'(m_bw));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic [31:0] sa, input logic en,
                         input logic [63:0] v, input logic [63:0] n, input logic fl);
        bus.start       = st;
        bus.start_addr  = sa;
        bus.enable      = en;
        bus.val         = v;
        bus.size_of_bit = n;
        bus.flush       = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, bus.start_addr, 1'b0, 64'h0, 64'h0, 1'b0);
    endtask

    initial begin
        logic        st, en, fl;
        logic [31:0] sa;
        logic [63:0] v, n;
        int          r;

        reset_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'h0, 64'h0, 1'b0);
        idle();
        reset_n = 1'b1;
        chk("rst_wr_en", 64'(bus.wr_en), 64'h0);
        chk("rst_bytes_written", 64'(bus.bytes_written), 64'h0);
        chk("rst_error", 64'(bus.error), 64'h0);
        chk("rst_busy_done", 64'({bus.busy, bus.done}), 64'h0);

        // Two codes, flush on the second: one byte 0xBF.
        drive(1'b1, 32'h100, 1'b0, 64'h0, 64'h0, 1'b0);
        drive(1'b0, 32'h100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0100_0000_0000_0003, 1'b0);
        chk("t1_no_write", 64'(bus.wr_en), 64'h0);
        drive(1'b0, 32'h100, 1'b1, 64'h1F, 64'd5, 1'b1);
        chk("t1_wr_en", 64'(bus.wr_en), 64'h1);
        chk("t1_addr", 64'(bus.wr_addr), 64'h100);
        chk("t1_data", 64'(bus.wr_data), 64'hBF00_0000);
        chk("t1_cnt", 64'(bus.wr_byte_cnt), 64'd1);
        chk("t1_done", 64'(bus.done), 64'h1);
        chk("t1_bytes_written", 64'(bus.bytes_written), 64'd1);

        // Eight 4-bit codes fill exactly one word.
        drive(1'b1, 32'h200, 1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 32'h200, 1'b1, 64'hF, 64'd4, 1'b0);
        chk("t2_no_early_write", 64'(bus.wr_en), 64'h0);
        drive(1'b0, 32'h200, 1'b1, 64'hF, 64'd4, 1'b0);
        chk("t2_wr_en", 64'(bus.wr_en), 64'h1);
        chk("t2_data", 64'(bus.wr_data), 64'hFFFF_FFFF);
        chk("t2_cnt", 64'(bus.wr_byte_cnt), 64'd4);
        chk("t2_no_done", 64'(bus.done), 64'h0);
        drive(1'b0, 32'h200, 1'b0, 64'h0, 64'h0, 1'b1);
        chk("t2_empty_flush_no_write", 64'(bus.wr_en), 64'h0);
        chk("t2_empty_flush_done", 64'(bus.done), 64'h1);

        // 31 ones then a 32-bit zero code with flush: two-word drain.
        drive(1'b1, 32'h300, 1'b0, 64'h0, 64'h0, 1'b0);
        drive(1'b0, 32'h300, 1'b1, 64'h7FFF_FFFF, 64'd31, 1'b0);
        drive(1'b0, 32'h300, 1'b1, 64'h0, 64'd32, 1'b1);
        chk("t3_w1_data", 64'(bus.wr_data), 64'hFFFF_FFFE);
        chk("t3_w1_cnt", 64'(bus.wr_byte_cnt), 64'd4);
        chk("t3_w1_busy_done", 64'({bus.busy, bus.done}), 64'h0);
        idle();
        chk("t3_w2_wr_en", 64'(bus.wr_en), 64'h1);
        chk("t3_w2_addr", 64'(bus.wr_addr), 64'h304);
        chk("t3_w2_data", 64'(bus.wr_data), 64'h0);
        chk("t3_w2_cnt", 64'(bus.wr_byte_cnt), 64'd4);
        chk("t3_w2_busy_done", 64'({bus.busy, bus.done}), 64'h3);
        chk("t3_bytes_written", 64'(bus.bytes_written), 64'd8);
        // enable while busy is illegal
        drive(1'b0, 32'h300, 1'b1, 64'h1, 64'd1, 1'b0);
        chk("t3_busy_enable_error", 64'(bus.error), 64'h1);
        chk("t3_busy_enable_no_write", 64'(bus.wr_en), 64'h0);

        // Back-to-back components continue the address.
        drive(1'b1, 32'h100, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("t4_start_clears_error", 64'(bus.error), 64'h0);
        drive(1'b0, 32'h100, 1'b1, 64'h3, 64'd2, 1'b1);
        chk("t4_c1_data", 64'(bus.wr_data), 64'hC000_0000);
        chk("t4_c1_addr", 64'(bus.wr_addr), 64'h100);
        drive(1'b0, 32'h100, 1'b1, 64'hAB, 64'd8, 1'b1);
        chk("t4_c2_addr", 64'(bus.wr_addr), 64'h101);
        chk("t4_c2_data", 64'(bus.wr_data), 64'hAB00_0000);
        chk("t4_c2_cnt", 64'(bus.wr_byte_cnt), 64'd1);

        // Oversized code is dropped and flags error.
        drive(1'b1, 32'h40, 1'b0, 64'h0, 64'h0, 1'b0);
        drive(1'b0, 32'h40, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd33, 1'b0);
        chk("t5_oversize_error", 64'(bus.error), 64'h1);
        chk("t5_oversize_no_write", 64'(bus.wr_en), 64'h0);
        drive(1'b0, 32'h40, 1'b1, 64'h1, 64'd1, 1'b1);
        chk("t5_buffer_unchanged", 64'(bus.wr_data), 64'h8000_0000);

        // Reset during the drain cycle.
        drive(1'b1, 32'h400, 1'b0, 64'h0, 64'h0, 1'b0);
        drive(1'b0, 32'h400, 1'b1, 64'h7FFF_FFFF, 64'd31, 1'b0);
        drive(1'b0, 32'h400, 1'b1, 64'h0, 64'd32, 1'b1);
        drive(1'b0, 32'h400, 1'b1, 64'h1, 64'd1, 1'b0);
        chk("t6_pre_reset_busy_err", 64'({bus.busy, bus.error}), 64'h3);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", 64'({bus.wr_en, bus.done, bus.busy, bus.error}), 64'h0);
        idle();
        reset_n = 1'b1;
        drive(1'b1, 32'h500, 1'b1, 64'hAB, 64'd8, 1'b1);
        chk("t6_new_addr", 64'(bus.wr_addr), 64'h500);
        chk("t6_new_data", 64'(bus.wr_data), 64'hAB00_0000);
        chk("t6_new_done", 64'(bus.done), 64'h1);

        // Randomized legal traffic, checked cycle by cycle against the model.
        sa = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 59) == 0);
            if (st) sa = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom);
            en = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 19) == 0);
            v  = {$urandom, $urandom};
            n  = {$urandom, $urandom};
            r  = $urandom_range(0, 99);
            if (r < 4)       n[6:0] = 7'($urandom_range(33, 127));
            else if (r < 8)  n[6:0] = 7'd0;
            else if (r < 14) n[6:0] = 7'd32;
            else             n[6:0] = 7'($urandom_range(1, 32));
            if (!st && (m_drain_pending || m_busy_window)) begin
                en = 1'b0;
                fl = 1'b0;
            end
            drive(st, sa, en, v, n, fl);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_packer.md
# bitstream_packer

Bit-serial to byte-stream packer directly downstream of the per-component entropy coder. It consumes the variable-length code stream (enable / value / bit length / flush) that the component stage emits for DC and AC coefficients. It packs the codes MSB-first into big-endian bytes and writes them to the slice output memory as 32-bit words carrying a byte count. On flush it pads to a byte boundary, drains, and reports the component's size in bytes.

## Interface
Parameters:
- ADDR_W, 32, width of byte address and byte counters
- MAX_CODE_BITS, 32, largest legal code length per enable

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears buffer and counters, latches start_addr
- start_addr  in  ADDR_W  byte address of the first output byte
- enable  in  1  code valid this cycle
- val  in  64  code value, right-justified; bits at and above size_of_bit are ignored
- size_of_bit  in  64  code length; only [6:0] examined, legal 0..MAX_CODE_BITS
- flush  in  1  end of component; applies after this cycle's code
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  byte address of wr_data[31:24]
- wr_data  out  32  packed bytes, MSB-first; unused low bytes are zero
- wr_byte_cnt  out  3  valid bytes in wr_data, 1..4
- bytes_written  out  ADDR_W  bytes written since last start
- busy  out  1  draining after flush; enable/flush illegal while high
- done  out  1  one-cycle pulse on the last drain cycle
- error  out  1  sticky protocol error, cleared by start or reset

## Operation
- State: 64-bit left-justified bit buffer `buf`, fill count `fill` (0..63), FSM {RUN, DRAIN}.
- Reset and start: buf=0, fill=0, bytes_written=0, state=RUN, error=0. All outputs are 0 at reset. start also latches start_addr.
- RUN, enable with size n (1..32):
  - Append the n low bits of val at bit position 63-fill.
  - If the new fill ≥ 32: emit the top 32 bits (wr_byte_cnt=4), shift buf left 32, fill -= 32.
  - fill < 32 holds before every append, so the 64-bit buffer never overflows.
- n=0: no-op. n>32: code dropped, error set.
- flush (RUN):
  - After this cycle's append and emit, pad fill up to the next multiple of 8 with zero bits.
  - Padded fill ≤ 32: emit ceil(fill/8) bytes, or nothing if fill=0. done is asserted with that write and the FSM stays in RUN.
  - Padded fill > 32: emit 4 bytes and go to DRAIN; the next cycle emits the remaining 1..4 bytes with done, then returns to RUN.
- After flush completes, buf/fill are zero. bytes_written and the address continue, so back-to-back components pack contiguously until the next start.
- wr_addr = start_addr + bytes_written before the write. bytes_written increases by wr_byte_cnt on each write; it wraps modulo 2^ADDR_W.
- enable or flush while busy: input ignored, error set.
- start has priority over everything, including during DRAIN: a pending drain is aborted with no done. If enable arrives in the same cycle as start, the code is appended to the cleared buffer.

## Timing
- All outputs are registered. A code sampled at edge N produces its write (if any) in cycle N+1.
- Flush sampled at N: first write or done in N+1; if DRAIN is needed, the second write and done in N+2.
- busy is high exactly during the DRAIN cycle (N+2 case). done is never asserted without a preceding flush.
- Sustained throughput: one ≤32-bit code per cycle, no backpressure, at most one write per cycle.
- Reset mid-operation: all state cleared immediately, buffered bits lost, no write or done emitted.

## Structure
- Shared package prores_pkg:
  - constants WORD_BITS=32, BUF_BITS=64, MAX_CODE_BITS=32
  - typedef packer_state_t {RUN, DRAIN}
- One combinational sub-module, bit_append: inputs buf, fill, val, n; outputs the merged buffer and new fill. It covers masking and the variable shift.
- The top level holds the FSM, emit/shift logic and counters.

## Test plan
- start_addr=0x100; codes (0x5,3), (0x1F,5); flush with the last code → one write: addr 0x100, data 0xBF000000, cnt 1, done, bytes_written=1.
- Eight codes (0xF,4) → one write of 0xFFFFFFFF, cnt 4, in the cycle after the eighth code; fill=0; no done.
- fill=31 (all ones), then code (0x0,32) with flush → write 0xFFFFFFFE cnt 4; DRAIN; write 0x00000000 cnt 4 with done, busy high for that cycle, bytes_written=8.
- Code (0x3,2), flush → data 0xC0000000 cnt 1. Then start_addr unchanged, no start, code (0xAB,8), flush → addr 0x101, data 0xAB000000, cnt 1.
- size_of_bit=33 with enable → no write, error=1, buffer unchanged. enable during busy → error=1. start clears error.
- Assert reset_n low during DRAIN → wr_en, done, busy and error go to 0 immediately. After release, a first write lands at the newly latched start_addr.
